// File: rtl/riscv_lsu.sv
// Load-store unit: decodes size/alignment, runs a ready-handshake memory access
// and returns extended load data with misaligned, illegal-size and timeout errors.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_o,
    output logic        lsu_err_o,
    output logic [1:0]  lsu_err_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [31:0]     r_rdata, w_rdata_next;
    logic            r_timeout, w_timeout_next;

    logic            w_illegal, w_misalign;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;
    logic [31:0]     w_shift;
    logic [31:0]     w_load;
    logic            w_mem_req, w_stall, w_err;
    logic [1:0]      w_cause;

    // Access decode: legality, alignment, byte lanes and replicated store data.
    always_comb begin
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_wd       = 32'h0;
        unique case (lsu_size_i)
            3'd0, 3'd4: begin
                w_be = 4'b0001 << lsu_addr_i[1:0];
                w_wd = {4{lsu_data_i[7:0]}};
            end
            3'd1, 3'd5: begin
                w_misalign = lsu_addr_i[0];
                w_be       = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wd       = {2{lsu_data_i[15:0]}};
            end
            3'd2: begin
                w_misalign = (lsu_addr_i[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wd       = lsu_data_i;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_rdata_next   = r_rdata;
        w_timeout_next = r_timeout;
        w_mem_req      = 1'b0;
        w_stall        = 1'b0;
        w_err          = 1'b0;
        w_cause        = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (lsu_req_i) begin
                    if (w_illegal) begin
                        w_err   = 1'b1;
                        w_cause = 2'b10;
                    end else if (w_misalign) begin
                        w_err   = 1'b1;
                        w_cause = 2'b01;
                    end else begin
                        w_mem_req      = 1'b1;
                        w_stall        = 1'b1;
                        w_timeout_next = 1'b0;
                        if (mem_ready_i) begin
                            w_rdata_next = mem_rd_i;
                            w_state_next = StResp;
                        end else begin
                            w_cnt_next   = '0;
                            w_state_next = StWait;
                        end
                    end
                end
            end
            StWait: begin
                // lsu_req_i is deliberately ignored here; the access always completes.
                w_mem_req = 1'b1;
                w_stall   = 1'b1;
                if (mem_ready_i) begin
                    w_rdata_next = mem_rd_i;
                    w_state_next = StResp;
                end else if ((TIMEOUT != 0) && (r_cnt == CntMax)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = StResp;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StResp: begin
                w_state_next = StIdle;
                if (r_timeout) begin
                    w_err   = 1'b1;
                    w_cause = 2'b11;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Load extraction from the latched word; size/addr are held stable through RESP.
    always_comb begin
        w_shift = r_rdata >> {lsu_addr_i[1:0], 3'b000};
        w_load  = 32'h0;
        unique case (lsu_size_i)
            3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd4:    w_load = {24'h0, w_shift[7:0]};
            3'd1:    w_load = lsu_addr_i[1] ? {{16{r_rdata[31]}}, r_rdata[31:16]}
                                            : {{16{r_rdata[15]}}, r_rdata[15:0]};
            3'd5:    w_load = lsu_addr_i[1] ? {16'h0, r_rdata[31:16]} : {16'h0, r_rdata[15:0]};
            3'd2:    w_load = r_rdata;
            default: w_load = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_rdata   <= 32'h0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rdata   <= w_rdata_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign mem_req_o       = w_mem_req & ~rst_i;
    assign mem_we_o        = mem_req_o & lsu_we_i;
    assign mem_be_o        = mem_req_o ? w_be : 4'b0000;
    assign mem_addr_o      = mem_req_o ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_wd_o        = mem_req_o ? w_wd : 32'h0;
    assign lsu_stall_o     = w_stall & ~rst_i;
    assign lsu_err_o       = w_err & ~rst_i;
    assign lsu_err_cause_o = rst_i ? 2'b00 : w_cause;
    assign lsu_data_o      = (!rst_i && (r_state == StResp) && !lsu_we_i && !r_timeout)
                             ? w_load : 32'h0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: RESP results are checked against a scoreboard
// queue filled when each access is launched.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_o, lsu_err_o;
    logic [1:0]  lsu_err_cause_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    riscv_lsu #(.TIMEOUT(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_data_o     (lsu_data_o),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_err_o      (lsu_err_o),
        .lsu_err_cause_o(lsu_err_cause_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i),
        .mem_ready_i    (mem_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] data, input logic err, input logic [1:0] cause);
        exp_t e;
        e.data  = data;
        e.err   = err;
        e.cause = cause;
        sb.push_back(e);
    endtask

    // Launch from IDLE; ready is raised on stall cycle index rdy_after (-1 = never).
    task automatic access(input string tag, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rw, input int rdy_after, input int exp_stall,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
        int   stalls;
        int   reqs;
        logic hold_ok;
        exp_t e;
        stalls  = 0;
        reqs    = 0;
        hold_ok = 1'b1;
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_size_i  = sz;
        lsu_addr_i  = addr;
        lsu_data_i  = wd;
        mem_rd_i    = rw;
        mem_ready_i = (rdy_after == 0);
        #1;
        check({tag, "_we"}, {31'h0, mem_we_o}, {31'h0, we});
        while (lsu_stall_o === 1'b1 && stalls < 64) begin
            if (mem_req_o === 1'b1) reqs++;
            if (mem_addr_o !== exp_addr || mem_be_o !== exp_be || mem_wd_o !== exp_wd)
                hold_ok = 1'b0;
            stalls++;
            cyc();
            mem_ready_i = (rdy_after >= 0) && (stalls == rdy_after);
            #1;
        end
        check({tag, "_stall_cycles"}, stalls, exp_stall);
        check({tag, "_req_cycles"}, reqs, exp_stall);
        check({tag, "_mem_fields"}, {31'h0, hold_ok}, 32'h1);
        check({tag, "_resp_req"}, {31'h0, mem_req_o}, 32'h0);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, lsu_data_o, e.data);
            check({tag, "_err"}, {31'h0, lsu_err_o}, {31'h0, e.err});
            check({tag, "_cause"}, {30'h0, lsu_err_cause_o}, {30'h0, e.cause});
        end
        mem_ready_i = 1'b0;
        cyc();
        lsu_req_i = 1'b0;
        #1;
        check({tag, "_idle_stall"}, {31'h0, lsu_stall_o}, 32'h0);
        check({tag, "_idle_data"}, lsu_data_o, 32'h0);
    endtask

    task automatic bad_req(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                           input logic [1:0] exp_cause);
        cyc();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = sz;
        lsu_addr_i = addr;
        #1;
        check({tag, "_req"}, {31'h0, mem_req_o}, 32'h0);
        check({tag, "_stall"}, {31'h0, lsu_stall_o}, 32'h0);
        check({tag, "_err"}, {31'h0, lsu_err_o}, 32'h1);
        check({tag, "_cause"}, {30'h0, lsu_err_cause_o}, {30'h0, exp_cause});
        cyc();
        lsu_req_i = 1'b0;
        #1;
        check({tag, "_err_clear"}, {31'h0, lsu_err_o}, 32'h0);
    endtask

    initial begin
        rst_i       = 1'b1;
        lsu_req_i   = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 3'd2;
        lsu_addr_i  = 32'h0;
        lsu_data_i  = 32'h0;
        mem_rd_i    = 32'h0;
        mem_ready_i = 1'b0;
        cyc();
        cyc();
        check("rst_req", {31'h0, mem_req_o}, 32'h0);
        check("rst_stall", {31'h0, lsu_stall_o}, 32'h0);
        check("rst_err", {31'h0, lsu_err_o}, 32'h0);
        rst_i     = 1'b0;
        lsu_req_i = 1'b0;
        cyc();
        check("idle_data", lsu_data_o, 32'h0);

        push(32'hFFFF_FF80, 1'b0, 2'b00);
        access("lb", 1'b0, 3'd0, 32'h103, 32'h11, 32'h80FF_1234, 0, 1,
               32'h100, 4'b1000, 32'h1111_1111);
        push(32'h0000_0080, 1'b0, 2'b00);
        access("lbu", 1'b0, 3'd4, 32'h103, 32'h11, 32'h80FF_1234, 0, 1,
               32'h100, 4'b1000, 32'h1111_1111);
        push(32'h0, 1'b0, 2'b00);
        access("sh", 1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 3, 4,
               32'h200, 4'b1100, 32'hABCD_ABCD);
        push(32'h0, 1'b0, 2'b00);
        access("sw", 1'b1, 3'd2, 32'h404, 32'hDEAD_BEEF, 32'h0, 1, 2,
               32'h404, 4'b1111, 32'hDEAD_BEEF);
        push(32'h0, 1'b0, 2'b00);
        access("sb", 1'b1, 3'd0, 32'h501, 32'h0000_00A5, 32'h0, 0, 1,
               32'h500, 4'b0010, 32'hA5A5_A5A5);
        push(32'hCAFE_F00D, 1'b0, 2'b00);
        access("lw", 1'b0, 3'd2, 32'h408, 32'h0, 32'hCAFE_F00D, 2, 3,
               32'h408, 4'b1111, 32'h0);
        push(32'h0000_7FFF, 1'b0, 2'b00);
        access("lh_hi", 1'b0, 3'd1, 32'h302, 32'h0, 32'h7FFF_0001, 0, 1,
               32'h300, 4'b1100, 32'h0);
        push(32'h0000_8001, 1'b0, 2'b00);
        access("lhu_lo", 1'b0, 3'd5, 32'h300, 32'h0, 32'h0000_8001, 0, 1,
               32'h300, 4'b0011, 32'h0);
        push(32'hFFFF_8001, 1'b0, 2'b00);
        access("lh_lo", 1'b0, 3'd1, 32'h300, 32'h0, 32'h0000_8001, 1, 2,
               32'h300, 4'b0011, 32'h0);

        bad_req("lw_misal", 3'd2, 32'h106, 2'b01);
        bad_req("lh_misal", 3'd1, 32'h301, 2'b01);
        bad_req("sz3", 3'd3, 32'h100, 2'b10);
        bad_req("sz6_prio", 3'd6, 32'h101, 2'b10);

        push(32'h0, 1'b1, 2'b11);
        access("tmo", 1'b0, 3'd2, 32'h600, 32'h0, 32'hFFFF_FFFF, -1, 17,
               32'h600, 4'b1111, 32'h0);

        // Reset landing in the second WAIT cycle.
        cyc();
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h700;
        #1;
        check("mrst_idle_stall", {31'h0, lsu_stall_o}, 32'h1);
        cyc();
        check("mrst_wait1_req", {31'h0, mem_req_o}, 32'h1);
        cyc();
        rst_i = 1'b1;
        #1;
        check("mrst_req", {31'h0, mem_req_o}, 32'h0);
        check("mrst_stall", {31'h0, lsu_stall_o}, 32'h0);
        cyc();
        rst_i     = 1'b0;
        lsu_req_i = 1'b0;
        #1;
        check("mrst_after_stall", {31'h0, lsu_stall_o}, 32'h0);
        check("mrst_after_data", lsu_data_o, 32'h0);
        push(32'h0, 1'b1, 2'b11);
        access("tmo2", 1'b0, 3'd2, 32'h700, 32'h0, 32'h1234_5678, -1, 17,
               32'h700, 4'b1111, 32'h0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
